// File: rtl/amber_gwddr_ui_model.sv
// Behavioural model of a DDR controller user interface: a calibration delay,
// single-outstanding WR/RD commands, fixed-latency read bursts, byte-masked
// writes into an internal backing store, and a sticky protocol-error flag.
module amber_gwddr_ui_model #(
  parameter int USER_DATA_W  = 128,
  parameter int ADDR_W       = 32,
  parameter int MEM_AW       = 10,
  parameter int CALIB_CYCLES = 16,
  parameter int RD_LATENCY   = 4,
  parameter int BEATS        = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     init_calib_complete,
  input  logic                     cmd_en,
  input  logic [2:0]               cmd,
  input  logic [ADDR_W-1:0]        addr,
  output logic                     cmd_ready,
  input  logic [USER_DATA_W-1:0]   wr_data,
  input  logic                     wr_data_en,
  input  logic                     wr_data_end,
  output logic                     wr_data_rdy,
  input  logic [USER_DATA_W/8-1:0] wr_data_mask,
  output logic [USER_DATA_W-1:0]   rd_data,
  output logic                     rd_data_valid,
  output logic                     rd_data_end,
  output logic                     proto_err
);

  localparam int NB    = USER_DATA_W / 8;
  localparam int CW    = (CALIB_CYCLES > 1) ? $clog2(CALIB_CYCLES) : 1;
  localparam int LW    = $clog2(RD_LATENCY + 1);
  localparam int DEPTH = 1 << MEM_AW;
  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  typedef enum logic [2:0] {CALIB, IDLE, WR_DATA, RD_WAIT, RD_BURST} state_e;

  state_e                   state_q, state_d;
  logic [CW-1:0]            cal_cnt_q, cal_cnt_d;
  logic                     calib_q, calib_d;
  logic [MEM_AW-1:0]        idx_q, idx_d;
  logic [2:0]               beat_q, beat_d;
  logic [LW-1:0]            lat_q, lat_d;
  logic                     err_q, err_d;
  logic                     rvalid_q, rvalid_d;
  logic                     rend_q, rend_d;
  logic [USER_DATA_W-1:0]   rdata_q, rdata_d;
  logic                     mem_we;
  logic [MEM_AW-1:0]        mem_wa;
  logic [MEM_AW-1:0]        beat_addr;
  logic                     unused_addr;

  logic [USER_DATA_W-1:0]   mem_q [DEPTH];

  assign beat_addr   = idx_q + MEM_AW'(beat_q);
  assign unused_addr = ^addr;

  assign init_calib_complete = calib_q;
  assign cmd_ready           = (state_q == IDLE);
  assign wr_data_rdy         = (state_q == IDLE) || (state_q == WR_DATA);
  assign rd_data             = rdata_q;
  assign rd_data_valid       = rvalid_q;
  assign rd_data_end         = rend_q;
  assign proto_err           = err_q;

  // Next-state, store write strobe and read-beat generation.
  always_comb begin
    state_d   = state_q;
    cal_cnt_d = cal_cnt_q;
    calib_d   = calib_q;
    idx_d     = idx_q;
    beat_d    = beat_q;
    lat_d     = lat_q;
    err_d     = err_q;
    rvalid_d  = 1'b0;
    rend_d    = 1'b0;
    rdata_d   = '0;
    mem_we    = 1'b0;
    mem_wa    = beat_addr;
    case (state_q)
      CALIB: begin
        if (cal_cnt_q == CW'(CALIB_CYCLES - 1)) begin
          state_d = IDLE;
          calib_d = 1'b1;
        end else begin
          cal_cnt_d = cal_cnt_q + CW'(1);
        end
      end
      IDLE: begin
        if (cmd_en && cmd == CMD_WR) begin
          idx_d   = addr[MEM_AW-1:0];
          beat_d  = '0;
          state_d = WR_DATA;
          // A beat arriving with the command is beat 0; it may also finish the burst.
          if (wr_data_en) begin
            mem_we = 1'b1;
            mem_wa = addr[MEM_AW-1:0];
            beat_d = 3'd1;
            if (BEATS == 1) begin
              state_d = IDLE;
            end else if (wr_data_end) begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end
        end else begin
          if (wr_data_en) err_d = 1'b1;
          if (cmd_en && cmd == CMD_RD) begin
            idx_d   = addr[MEM_AW-1:0];
            beat_d  = '0;
            lat_d   = LW'(1);
            state_d = RD_WAIT;
          end else if (cmd_en) begin
            err_d = 1'b1;
          end
        end
      end
      WR_DATA: begin
        if (wr_data_en) begin
          mem_we = 1'b1;
          beat_d = beat_q + 3'd1;
          if (beat_q == 3'(BEATS - 1)) begin
            state_d = IDLE;
          end else if (wr_data_end) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      RD_WAIT: begin
        if (lat_q == LW'(RD_LATENCY)) begin
          state_d  = RD_BURST;
          rvalid_d = 1'b1;
          rend_d   = (BEATS == 1);
          rdata_d  = mem_q[beat_addr];
          beat_d   = 3'd1;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      RD_BURST: begin
        if (beat_q == 3'(BEATS)) begin
          state_d = IDLE;
        end else begin
          rvalid_d = 1'b1;
          rend_d   = (beat_q == 3'(BEATS - 1));
          rdata_d  = mem_q[beat_addr];
          beat_d   = beat_q + 3'd1;
        end
      end
      default: state_d = CALIB;
    endcase
  end

  // Control and read-output registers; reset aborts any burst and restarts calibration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CALIB;
      cal_cnt_q <= '0;
      calib_q   <= 1'b0;
      idx_q     <= '0;
      beat_q    <= '0;
      lat_q     <= '0;
      err_q     <= 1'b0;
      rvalid_q  <= 1'b0;
      rend_q    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cal_cnt_q <= cal_cnt_d;
      calib_q   <= calib_d;
      idx_q     <= idx_d;
      beat_q    <= beat_d;
      lat_q     <= lat_d;
      err_q     <= err_d;
      rvalid_q  <= rvalid_d;
      rend_q    <= rend_d;
      rdata_q   <= rdata_d;
    end
  end

  // Backing store: byte-masked writes, contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (!wr_data_mask[b]) mem_q[mem_wa][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_amber_gwddr_ui_model.sv
// Bench for amber_gwddr_ui_model: timeline-based reference model plus
// directed scenarios with literal expectations and a randomized phase.
module tb_amber_gwddr_ui_model;

  localparam int W     = 128;
  localparam int NB    = W / 8;
  localparam int AW    = 32;
  localparam int MAW   = 10;
  localparam int CAL   = 16;
  localparam int RL    = 4;
  localparam int BEATS = 2;
  localparam int DEPTH = 1 << MAW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            init_calib_complete;
  logic            cmd_en = 1'b0;
  logic [2:0]      cmd = '0;
  logic [AW-1:0]   addr = '0;
  logic            cmd_ready;
  logic [W-1:0]    wr_data = '0;
  logic            wr_data_en = 1'b0;
  logic            wr_data_end = 1'b0;
  logic            wr_data_rdy;
  logic [NB-1:0]   wr_data_mask = '0;
  logic [W-1:0]    rd_data;
  logic            rd_data_valid;
  logic            rd_data_end;
  logic            proto_err;

  amber_gwddr_ui_model #(
    .USER_DATA_W (W),
    .ADDR_W      (AW),
    .MEM_AW      (MAW),
    .CALIB_CYCLES(CAL),
    .RD_LATENCY  (RL),
    .BEATS       (BEATS)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .init_calib_complete(init_calib_complete),
    .cmd_en             (cmd_en),
    .cmd                (cmd),
    .addr               (addr),
    .cmd_ready          (cmd_ready),
    .wr_data            (wr_data),
    .wr_data_en         (wr_data_en),
    .wr_data_end        (wr_data_end),
    .wr_data_rdy        (wr_data_rdy),
    .wr_data_mask       (wr_data_mask),
    .rd_data            (rd_data),
    .rd_data_valid      (rd_data_valid),
    .rd_data_end        (rd_data_end),
    .proto_err          (proto_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Edge count since reset release, write beats still owed, edge from which
  // a read no longer occupies the interface, and scheduled read beats.
  typedef struct {
    int           at;
    logic [W-1:0] d;
    logic [W-1:0] k;
    bit           last;
  } beat_t;

  logic [W-1:0]  mm    [DEPTH];
  logic [NB-1:0] known [DEPTH];
  int            m_e, m_wl, m_wk, m_busy;
  logic [MAW-1:0] m_wi;
  bit            m_err;
  beat_t         rq[$];

  function automatic logic [W-1:0] kexp(input logic [NB-1:0] k);
    logic [W-1:0] r;
    for (int b = 0; b < NB; b++) r[8*b +: 8] = {8{k[b]}};
    return r;
  endfunction

  task automatic m_beat();
    logic [MAW-1:0] ix;
    ix = m_wi + MAW'(m_wk);
    for (int b = 0; b < NB; b++) begin
      if (!wr_data_mask[b]) begin
        mm[ix][8*b +: 8] = wr_data[8*b +: 8];
        known[ix][b] = 1'b1;
      end
    end
    m_wk++;
    m_wl--;
    if (wr_data_end && m_wl > 0) begin
      m_err = 1'b1;
      m_wl  = 0;
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      known[i] = '0;
      mm[i]    = '0;
    end
  end

  always @(posedge clk or negedge rst_n) begin : model
    bit    idle;
    int    n;
    beat_t bt;
    logic [MAW-1:0] ix;
    if (!rst_n) begin
      m_e = 0; m_err = 1'b0; m_wl = 0; m_busy = 0;
      rq.delete();
    end else begin
      idle = (m_e >= CAL) && (m_wl == 0) && (m_e >= m_busy);
      n = m_e + 1;
      if (idle) begin
        if (cmd_en && cmd == 3'b000) begin
          m_wl = BEATS; m_wk = 0; m_wi = addr[MAW-1:0];
          if (wr_data_en) m_beat();
        end else begin
          if (wr_data_en) m_err = 1'b1;
          if (cmd_en && cmd == 3'b001) begin
            for (int j = 0; j < BEATS; j++) begin
              ix      = addr[MAW-1:0] + MAW'(j);
              bt.at   = n + RL + j;
              bt.d    = mm[ix];
              bt.k    = kexp(known[ix]);
              bt.last = (j == BEATS - 1);
              rq.push_back(bt);
            end
            m_busy = n + RL + BEATS;
          end else if (cmd_en) begin
            m_err = 1'b1;
          end
        end
      end else if (m_wl > 0 && wr_data_en) begin
        m_beat();
      end
      m_e = n;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin : compare
    bit           e_cal, e_rdy, e_wrdy, e_v, e_end;
    logic [W-1:0] e_d, e_k;
    e_cal  = rst_n && (m_e >= CAL);
    e_rdy  = e_cal && (m_wl == 0) && (m_e >= m_busy);
    e_wrdy = e_cal && (m_e >= m_busy);
    e_v = 1'b0; e_end = 1'b0; e_d = '0; e_k = '1;
    while (rq.size() > 0 && rq[0].at < m_e) void'(rq.pop_front());
    if (rq.size() > 0 && rq[0].at == m_e) begin
      e_v = 1'b1; e_end = rq[0].last; e_d = rq[0].d; e_k = rq[0].k;
      void'(rq.pop_front());
    end
    chk("calib", W'(init_calib_complete), W'(e_cal));
    chk("cmd_ready", W'(cmd_ready), W'(e_rdy));
    chk("wr_data_rdy", W'(wr_data_rdy), W'(e_wrdy));
    chk("rd_valid", W'(rd_data_valid), W'(e_v));
    chk("rd_end", W'(rd_data_end), W'(e_end));
    chk("rd_data", rd_data & e_k, e_d & e_k);
    chk("proto_err", W'(proto_err), W'(m_err));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    cmd_en = 1'b0; cmd = '0; wr_data_en = 1'b0; wr_data_end = 1'b0; wr_data_mask = '0;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 200; i++) begin
      if (cmd_ready) return;
      tick();
    end
    chk("wait_ready_timeout", W'(cmd_ready), W'(1));
  endtask

  task automatic do_wr(input logic [AW-1:0] a, input logic [W-1:0] d0, input logic [NB-1:0] m0,
                       input logic [W-1:0] d1, input logic [NB-1:0] m1);
    wait_ready();
    cmd_en = 1'b1; cmd = 3'b000; addr = a;
    wr_data_en = 1'b1; wr_data = d0; wr_data_mask = m0; wr_data_end = 1'b0;
    tick();
    cmd_en = 1'b0; wr_data = d1; wr_data_mask = m1; wr_data_end = 1'b1;
    tick();
    idle_in();
  endtask

  task automatic do_rd(input logic [AW-1:0] a, output logic [W-1:0] g0, output logic [W-1:0] g1);
    g0 = '0; g1 = '0;
    wait_ready();
    cmd_en = 1'b1; cmd = 3'b001; addr = a;
    tick();
    cmd_en = 1'b0;
    for (int j = 1; j <= RL + BEATS - 1; j++) begin
      tick();
      chk("rd_valid_timing", W'(rd_data_valid), W'(j >= RL));
      chk("rd_end_timing", W'(rd_data_end), W'(j == RL + BEATS - 1));
      if (j == RL) g0 = rd_data;
      if (j == RL + 1) g1 = rd_data;
    end
  endtask

  logic [W-1:0] g0, g1;
  logic [W-1:0] va, vb;

  initial begin
    idle_in();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 1; i <= CAL; i++) begin
      tick();
      chk("calib_after_release", W'(init_calib_complete), W'(i >= CAL));
      chk("cmd_ready_after_release", W'(cmd_ready), W'(i >= CAL));
    end

    // Write with beat 0 in the command cycle, read it back.
    do_wr(32'h0000_0005, 128'h00ABCDEF, '0, 128'h1234, '0);
    do_rd(32'h0000_0005, g0, g1);
    chk("wr_rd_beat0", g0, 128'h00ABCDEF);
    chk("wr_rd_beat1", g1, 128'h1234);

    // Only byte 0 unmasked; second beat fully masked.
    do_wr(32'h0000_0005, '1, 16'hFFFE, '1, 16'hFFFF);
    do_rd(32'h0000_0005, g0, g1);
    chk("mask_byte0", g0, 128'h00ABCDFF);
    chk("mask_none", g1, 128'h1234);

    // Burst wraps from the top index to index 0; upper addr bits ignored.
    va = 128'hAAAA_0000_1111_2222_3333_4444_5555_6666;
    vb = 128'hBBBB_7777_8888_9999_CCCC_DDDD_EEEE_FFFF;
    do_wr(32'hFFFF_F3FF, va, '0, vb, '0);
    do_rd(32'h0000_03FF, g0, g1);
    chk("wrap_beatA", g0, va);
    chk("wrap_beatB", g1, vb);
    chk("err_clean", W'(proto_err), W'(0));

    // Unknown command, then a stray write beat in IDLE.
    wait_ready();
    cmd_en = 1'b1; cmd = 3'b010; addr = 32'h3FF;
    tick();
    idle_in();
    chk("err_bad_cmd", W'(proto_err), W'(1));
    chk("bad_cmd_stays_idle", W'(cmd_ready), W'(1));
    repeat (3) tick();
    wr_data_en = 1'b1; wr_data = '0; wr_data_end = 1'b1;
    tick();
    idle_in();
    chk("err_sticky", W'(proto_err), W'(1));
    do_rd(32'h0000_03FF, g0, g1);
    chk("store_unchanged_A", g0, va);
    chk("store_unchanged_B", g1, vb);

    // Reset while a read is waiting for its latency.
    wait_ready();
    cmd_en = 1'b1; cmd = 3'b001; addr = 32'h5;
    tick();
    cmd_en = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("no_valid_after_abort", W'(rd_data_valid), W'(0));
    end
    rst_n = 1'b1;
    for (int i = 1; i <= CAL; i++) begin
      tick();
      chk("no_valid_recal", W'(rd_data_valid), W'(0));
      if (i >= CAL - 1) chk("recal_ready", W'(cmd_ready), W'(i == CAL));
    end
    chk("err_cleared", W'(proto_err), W'(0));

    // Randomized traffic; the compare process checks every cycle.
    for (int it = 0; it < 3000; it++) begin
      logic [AW-1:0] a;
      int r;
      tick();
      if (it % 400 == 399) begin
        idle_in();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
      end
      cmd_en = ($urandom_range(0, 99) < 30);
      r = int'($urandom_range(0, 9));
      cmd = (r < 5) ? 3'b000 : (r < 9) ? 3'b001 : 3'($urandom_range(2, 7));
      a = $urandom();
      a[MAW-1:0] = ($urandom_range(0, 1) == 1) ? MAW'($urandom_range(0, 7))
                                               : MAW'($urandom_range(DEPTH - 4, DEPTH - 1));
      addr = a;
      wr_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      wr_data_mask = ($urandom_range(0, 1) == 1) ? '0 : NB'($urandom());
      if (m_wl > 0)                    wr_data_en = ($urandom_range(0, 99) < 70);
      else if (cmd_en && cmd == 3'b000) wr_data_en = ($urandom_range(0, 99) < 60);
      else                              wr_data_en = ($urandom_range(0, 99) < 2);
      wr_data_end = ($urandom_range(0, 1) == 1);
    end
    idle_in();
    repeat (10) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/amber_gwddr_ui_model.md
AMBER_GWDDR_UI_MODEL -- requirements
Module: amber_gwddr_ui_model

Interface
REQ-001 SHALL have parameter USER_DATA_W, default 128, user data bus width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_W, default 32, command address width.
REQ-003 SHALL have parameter MEM_AW, default 10, log2 of backing-store depth in USER_DATA_W beats.
REQ-004 SHALL have parameter CALIB_CYCLES, default 16, cycles from reset release to calibration complete (>=1).
REQ-005 SHALL have parameter RD_LATENCY, default 4, cycles from read-command acceptance to first read beat (>=2).
REQ-006 SHALL have parameter BEATS, default 1, data beats per command (1..4).
REQ-007 SHALL have ports: clk  in  1  sole clock, rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-008 SHALL have ports: init_calib_complete  out  1  calibration done; cmd_en  in  1  command strobe; cmd  in  3  000=WR, 001=RD; addr  in  ADDR_W  beat address; cmd_ready  out  1  command accepted when high with cmd_en.
REQ-009 SHALL have ports: wr_data  in  USER_DATA_W  write beat; wr_data_en  in  1  beat strobe; wr_data_end  in  1  last beat marker; wr_data_rdy  out  1  beat accepted when high with wr_data_en; wr_data_mask  in  USER_DATA_W/8  byte mask, 1 = byte not written.
REQ-010 SHALL have ports: rd_data  out  USER_DATA_W  read beat; rd_data_valid  out  1  beat valid; rd_data_end  out  1  last beat of burst; proto_err  out  1  sticky protocol-violation flag.

Function
REQ-011 SHALL implement states CALIB, IDLE, WR_DATA, RD_WAIT, RD_BURST.
REQ-012 SHALL stay in CALIB for exactly CALIB_CYCLES cycles after rst_n deasserts, then enter IDLE and hold init_calib_complete=1 until next reset.
REQ-013 SHALL drive cmd_ready=1 only in IDLE; a command is accepted on a rising edge with cmd_en=1 and cmd_ready=1; cmd_en outside IDLE is ignored with no error.
REQ-014 SHALL latch beat index = addr[MEM_AW-1:0] at acceptance; upper addr bits ignored; beat k of a burst uses (index+k) mod 2^MEM_AW.
REQ-015 SHALL on accepted WR enter WR_DATA; wr_data_rdy=1 in IDLE and WR_DATA.
REQ-016 SHALL capture a wr_data_en beat presented in the same cycle as the accepted WR command as beat 0.
REQ-017 SHALL write each accepted beat to the store byte-wise, updating only bytes whose mask bit is 0.
REQ-018 SHALL return from WR_DATA to IDLE after BEATS beats; wr_data_end on a beat other than the last sets proto_err, and that beat still completes the write (burst terminates, remaining beats not written).
REQ-019 SHALL on wr_data_en=1 in IDLE without an accepted WR command drop the beat and set proto_err.
REQ-020 SHALL on accepted RD (acceptance edge T) enter RD_WAIT and assert rd_data_valid from edge T+RD_LATENCY for BEATS consecutive cycles (RD_BURST), rd_data_end=1 only with the last beat, then return to IDLE.
REQ-021 SHALL present rd_data equal to store contents at the beat index, including writes completed before the RD acceptance edge.
REQ-022 SHALL drive rd_data=0 whenever rd_data_valid=0.
REQ-023 SHALL on accepted cmd other than 000/001 set proto_err, perform no access, remain in IDLE.
REQ-024 SHALL never have more than one command outstanding.
REQ-025 SHALL keep proto_err set until reset.

Reset
REQ-026 SHALL on rst_n=0, asynchronously: state=CALIB, calib counter=0, init_calib_complete=0, cmd_ready=0, wr_data_rdy=0, rd_data_valid=0, rd_data_end=0, rd_data=0, proto_err=0.
REQ-027 SHALL abort any in-flight burst on reset mid-operation (no further beats) and restart calibration on release.
REQ-028 SHALL NOT clear backing-store contents on reset; contents are undefined after power-up.

Verification
REQ-029 Release rst_n, idle -> init_calib_complete and cmd_ready rise exactly CALIB_CYCLES (16) cycles later; both 0 before.
REQ-030 WR addr=0x5, wr_data=0x...00ABCDEF, mask=0, same cycle as cmd; then RD addr=0x5 -> rd_data_valid and rd_data_end high exactly 4 cycles after RD acceptance, rd_data=0x...00ABCDEF.
REQ-031 WR addr=0x5 data all-ones, mask=0xFFFE -> subsequent RD returns prior word with only byte 0 = 0xFF.
REQ-032 BEATS=2, WR addr=0x3FF two beats A,B; RD addr=0x3FF -> beats A then B (wrapped to index 0), rd_data_end only on B.
REQ-033 cmd=010 accepted; later wr_data_en in IDLE without cmd -> proto_err=1 and stays 1, store unchanged.
REQ-034 rst_n low during RD_WAIT -> no rd_data_valid ever appears; after release, cmd_ready reasserts 16 cycles later and proto_err=0.
